// File: rtl/c_ext_fetch_state_pkg.sv
// Shared IF-stage definitions for the C-extension fetch state: spanning FSM
// encoding and parcel constants.
package c_ext_fetch_state_pkg;

    localparam int          PARCEL_W       = 16;
    localparam logic [1:0]  RVC_OPCODE_32B = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_READY   = 3'd2,
        ST_HW_HOLD = 3'd3,
        ST_BUF_USE = 3'd4
    } c_ext_state_e;

endpackage

// File: rtl/c_ext_fetch_state_stall.sv
// Stall snapshot: remembers the aligner flags present when a stall begins so
// the aligner can replay them once the pipeline resumes.
module c_ext_stall_snapshot (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_stall,
    input  logic i_flush,
    input  logic i_prev_was_compressed_at_lo,
    input  logic i_is_compressed,
    output logic o_stall_registered,
    output logic o_prev_was_compressed_at_lo_saved,
    output logic o_is_compressed_saved,
    output logic o_saved_values_valid
);

    logic stall_registered_q;
    logic prev_saved_q;
    logic is_compressed_saved_q;
    logic saved_valid_q;
    logic snap_s;
    logic release_s;

    assign snap_s    = i_stall && !stall_registered_q && !i_flush;
    assign release_s = stall_registered_q && !i_stall;

    // Snapshot on the first stalled cycle; validity ends on flush or resume.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_registered_q    <= 1'b0;
            prev_saved_q          <= 1'b0;
            is_compressed_saved_q <= 1'b0;
            saved_valid_q         <= 1'b0;
        end else begin
            stall_registered_q <= i_stall;
            if (snap_s) begin
                prev_saved_q          <= i_prev_was_compressed_at_lo;
                is_compressed_saved_q <= i_is_compressed;
                saved_valid_q         <= 1'b1;
            end else if (i_flush || release_s) begin
                saved_valid_q <= 1'b0;
            end else begin
                saved_valid_q <= saved_valid_q;
            end
        end
    end

    assign o_stall_registered                = stall_registered_q;
    assign o_prev_was_compressed_at_lo_saved = prev_saved_q;
    assign o_is_compressed_saved             = is_compressed_saved_q;
    assign o_saved_values_valid              = saved_valid_q;

endmodule

// File: rtl/c_ext_fetch_state.sv
// C-extension fetch state for the IF-stage aligner: instruction buffer,
// compressed-at-lo flag, spanning-instruction FSM and stall snapshot.
module c_ext_fetch_state
    import c_ext_fetch_state_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [XLEN-1:0]     i_instr,
    input  logic [XLEN-1:0]     i_effective_instr,
    input  logic [XLEN-1:0]     i_pc_reg,
    input  logic                i_is_compressed,
    input  logic                i_holdoff,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_span_redirect,
    output logic [XLEN-1:0]     o_instr_buffer,
    output logic                o_prev_was_compressed_at_lo,
    output logic                o_spanning_wait_for_fetch,
    output logic                o_spanning_in_progress,
    output logic [PARCEL_W-1:0] o_spanning_buffer,
    output logic [PARCEL_W-1:0] o_spanning_second_half,
    output logic                o_spanning_to_halfword_registered,
    output logic                o_use_buffer_after_spanning,
    output logic                o_stall_registered,
    output logic                o_prev_was_compressed_at_lo_saved,
    output logic                o_is_compressed_saved,
    output logic                o_saved_values_valid
);

    c_ext_state_e        state_q, state_d;
    logic [XLEN-1:0]     instr_buffer_q, instr_buffer_d;
    logic                prev_lo_q, prev_lo_d;
    logic [PARCEL_W-1:0] span_buf_q, span_buf_d;
    logic [PARCEL_W-1:0] span_half_q, span_half_d;

    logic adv_s;
    logic pc_hi_s;
    logic lo_compressed_s;
    logic span_start_s;
    logic unused_s;

    assign adv_s   = !i_stall && !i_flush;
    assign pc_hi_s = i_pc_reg[1];
    assign lo_compressed_s = !pc_hi_s && i_is_compressed && !i_holdoff
                             && (state_q == ST_IDLE);
    // A 32-bit instruction starting at the upper halfword spans two fetch words.
    assign span_start_s = ((state_q == ST_IDLE) || (state_q == ST_BUF_USE))
                          && adv_s && pc_hi_s && !i_is_compressed && !i_holdoff;

    assign unused_s = ^{i_pc_reg[XLEN-1:2], i_pc_reg[0],
                        i_effective_instr[PARCEL_W-1:0]};

    // Next-state logic: flush clears, stall holds, otherwise advance.
    always_comb begin
        state_d        = state_q;
        instr_buffer_d = instr_buffer_q;
        prev_lo_d      = prev_lo_q;
        span_buf_d     = span_buf_q;
        span_half_d    = span_half_q;
        if (i_flush) begin
            state_d   = ST_IDLE;
            prev_lo_d = 1'b0;
        end else if (adv_s) begin
            prev_lo_d = lo_compressed_s;
            if (lo_compressed_s) begin
                instr_buffer_d = i_instr;
            end else begin
                instr_buffer_d = instr_buffer_q;
            end
            case (state_q)
                ST_IDLE, ST_BUF_USE: begin
                    if (span_start_s) begin
                        span_buf_d = i_effective_instr[XLEN-1:PARCEL_W];
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    span_half_d    = i_instr[PARCEL_W-1:0];
                    instr_buffer_d = i_instr;
                    state_d        = ST_READY;
                end
                // The PC after a span is halfword-aligned, so the BRAM word is stale.
                ST_READY: begin
                    if (i_span_redirect) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HW_HOLD;
                    end
                end
                ST_HW_HOLD: begin
                    state_d = ST_BUF_USE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and capture registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            instr_buffer_q <= {XLEN{1'b0}};
            prev_lo_q      <= 1'b0;
            span_buf_q     <= {PARCEL_W{1'b0}};
            span_half_q    <= {PARCEL_W{1'b0}};
        end else begin
            state_q        <= state_d;
            instr_buffer_q <= instr_buffer_d;
            prev_lo_q      <= prev_lo_d;
            span_buf_q     <= span_buf_d;
            span_half_q    <= span_half_d;
        end
    end

    c_ext_stall_snapshot u_snapshot (
        .i_clk                             (i_clk),
        .i_rst_n                           (i_rst_n),
        .i_stall                           (i_stall),
        .i_flush                           (i_flush),
        .i_prev_was_compressed_at_lo       (prev_lo_q),
        .i_is_compressed                   (i_is_compressed),
        .o_stall_registered                (o_stall_registered),
        .o_prev_was_compressed_at_lo_saved (o_prev_was_compressed_at_lo_saved),
        .o_is_compressed_saved             (o_is_compressed_saved),
        .o_saved_values_valid              (o_saved_values_valid)
    );

    assign o_instr_buffer                    = instr_buffer_q;
    assign o_prev_was_compressed_at_lo       = prev_lo_q;
    assign o_spanning_buffer                 = span_buf_q;
    assign o_spanning_second_half            = span_half_q;
    assign o_spanning_wait_for_fetch         = (state_q == ST_WAIT);
    assign o_spanning_in_progress            = (state_q == ST_READY);
    assign o_spanning_to_halfword_registered = (state_q == ST_HW_HOLD);
    assign o_use_buffer_after_spanning       = (state_q == ST_BUF_USE);

endmodule

// File: tb/tb_c_ext_fetch_state.sv
// Scoreboard bench for c_ext_fetch_state: directed scenarios plus random
// traffic compared each cycle against a behavioural model.
module tb_c_ext_fetch_state;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, eff, pc;
    logic        ic, ho, st, fl, rd;

    logic [31:0] o_instr_buffer;
    logic        o_prev, o_wait, o_inprog, o_hw, o_bufuse;
    logic [15:0] o_sbuf, o_shalf;
    logic        o_streg, o_prevsv, o_icsv, o_valid;

    always #5 clk = ~clk;

    c_ext_fetch_state #(.XLEN(32)) dut (
        .i_clk                             (clk),
        .i_rst_n                           (rst_n),
        .i_instr                           (instr),
        .i_effective_instr                 (eff),
        .i_pc_reg                          (pc),
        .i_is_compressed                   (ic),
        .i_holdoff                         (ho),
        .i_stall                           (st),
        .i_flush                           (fl),
        .i_span_redirect                   (rd),
        .o_instr_buffer                    (o_instr_buffer),
        .o_prev_was_compressed_at_lo       (o_prev),
        .o_spanning_wait_for_fetch         (o_wait),
        .o_spanning_in_progress            (o_inprog),
        .o_spanning_buffer                 (o_sbuf),
        .o_spanning_second_half            (o_shalf),
        .o_spanning_to_halfword_registered (o_hw),
        .o_use_buffer_after_spanning       (o_bufuse),
        .o_stall_registered                (o_streg),
        .o_prev_was_compressed_at_lo_saved (o_prevsv),
        .o_is_compressed_saved             (o_icsv),
        .o_saved_values_valid              (o_valid)
    );

    typedef logic [72:0] vec_t;
    vec_t exp_q[$];
    vec_t act_s;
    int   total = 0;
    int   bad   = 0;

    assign act_s = {o_instr_buffer, o_prev, o_wait, o_inprog, o_sbuf, o_shalf,
                    o_hw, o_bufuse, o_streg, o_prevsv, o_icsv, o_valid};

    // Model: span phase 0=none, 1=awaiting second word, 2=issuing, 3=stale NOP, 4=buffer use
    int          m_phase;
    logic [31:0] m_ibuf;
    logic [15:0] m_sbuf, m_shalf;
    logic        m_prev, m_streg, m_prevsv, m_icsv, m_valid;

    task automatic model_reset();
        m_phase = 0; m_ibuf = 32'h0; m_sbuf = 16'h0; m_shalf = 16'h0;
        m_prev = 1'b0; m_streg = 1'b0; m_prevsv = 1'b0; m_icsv = 1'b0; m_valid = 1'b0;
    endtask

    function automatic vec_t model_vec();
        return {m_ibuf, m_prev, m_phase == 1, m_phase == 2, m_sbuf, m_shalf,
                m_phase == 3, m_phase == 4, m_streg, m_prevsv, m_icsv, m_valid};
    endfunction

    task automatic model_clock();
        logic adv, lo_c, begin_span;
        adv = !st && !fl;
        if (st && !m_streg && !fl) begin
            m_prevsv = m_prev; m_icsv = ic; m_valid = 1'b1;
        end else if (fl || (m_streg && !st)) begin
            m_valid = 1'b0;
        end
        if (fl) begin
            m_phase = 0; m_prev = 1'b0;
        end else if (adv) begin
            lo_c       = !pc[1] && ic && !ho && (m_phase == 0);
            begin_span = (m_phase == 0 || m_phase == 4) && pc[1] && !ic && !ho;
            if (lo_c) m_ibuf = instr;
            if (begin_span) begin
                m_sbuf = eff[31:16]; m_phase = 1;
            end else if (m_phase == 1) begin
                m_shalf = instr[15:0]; m_ibuf = instr; m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = rd ? 0 : 3;
            end else if (m_phase == 3) begin
                m_phase = 4;
            end else begin
                m_phase = 0;
            end
            m_prev = lo_c;
        end
        m_streg = st;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then clock.
    task automatic step(input logic [31:0] a_instr, a_eff, a_pc,
                        input logic a_ic, a_ho, a_st, a_fl, a_rd);
        instr = a_instr; eff = a_eff; pc = a_pc;
        ic = a_ic; ho = a_ho; st = a_st; fl = a_fl; rd = a_rd;
        model_clock();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (act_s !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_s, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        instr = 32'h0; eff = 32'h0; pc = 32'h0;
        ic = 1'b0; ho = 1'b0; st = 1'b0; fl = 1'b0; rd = 1'b0;
        model_reset();
        #3;
        check("reset_outputs", {31'h0, |act_s}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Spanning instruction at PC 0x102
        step(32'hDEAD_BEEF, 32'h1234_0517, 32'h0000_0102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("span_first_half", {16'h0, o_sbuf}, 32'h0000_1234);
        check("span_wait", {31'h0, o_wait}, 32'h1);
        step(32'hFFFF_0123, 32'h0, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("span_second_half", {16'h0, o_shalf}, 32'h0000_0123);
        check("span_in_progress", {31'h0, o_inprog}, 32'h1);
        step(32'h0, 32'h0, 32'h0000_0106, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("span_hw_hold", {31'h0, o_hw}, 32'h1);
        step(32'h0, 32'h0, 32'h0000_0106, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("span_buf_use", {31'h0, o_bufuse}, 32'h1);
        step(32'h0, 32'h0, 32'h0000_0108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("span_back_idle", {30'h0, o_bufuse, o_wait}, 32'h0);

        // Compressed parcel in the low half
        step(32'h8082_4501, 32'h8082_4501, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lo_prev_flag", {31'h0, o_prev}, 32'h1);
        check("lo_instr_buffer", o_instr_buffer, 32'h8082_4501);

        // Three stalled cycles then release
        for (int i = 0; i < 3; i++) begin
            step(32'h0, 32'h0, 32'h0000_0102, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            check("stall_snapshot", {28'h0, o_prevsv, o_icsv, o_valid, o_streg}, 32'hF);
        end
        step(32'h0, 32'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_release", {30'h0, o_valid, o_streg}, 32'h0);

        // Flush during a stalled WAIT
        step(32'h0, 32'h7777_0000, 32'h0000_0102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 32'h0, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wait_stall_hold", {30'h0, o_wait, o_valid}, 32'h3);
        step(32'h0, 32'h0, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_clears", {29'h0, o_wait, o_prev, o_valid}, 32'h0);
        step(32'h0, 32'h0, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back span starting from BUF_USE, then redirect out of READY
        step(32'h0, 32'h5555_0000, 32'h0000_0202, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'hA5A7_0123, 32'h0, 32'h0000_0204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 32'h0, 32'h0000_0206, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 32'h0, 32'h0000_0206, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bufuse_reached", {31'h0, o_bufuse}, 32'h1);
        step(32'h0, 32'hA5A7_0123, 32'h0000_0206, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bufuse_restart_buf", {16'h0, o_sbuf}, 32'h0000_A5A7);
        check("bufuse_restart_wait", {31'h0, o_wait}, 32'h1);
        step(32'h1111_2222, 32'h0, 32'h0000_0208, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 32'h0, 32'h0000_020A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("redirect_to_idle", {29'h0, o_hw, o_inprog, o_bufuse}, 32'h0);

        // Reset asserted mid-READY
        step(32'h0, 32'hABCD_0000, 32'h0000_0302, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h3333_4444, 32'h0, 32'h0000_0304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_ready", {15'h0, o_inprog, o_sbuf}, 32'h0001_ABCD);
        rst_n = 1'b0;
        #1;
        check("async_reset", {31'h0, |act_s}, 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(32'h0, 32'h0, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_idle", {31'h0, |act_s}, 32'h0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom, $urandom, {$urandom_range(0, 255), 1'b0} << 1 | {30'h0, 1'($urandom_range(0, 1)), 1'b0},
                 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 3) == 0));
        end

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c_ext_fetch_state.md
Name: c_ext_fetch_state

Overview:
- Sequential companion to the instruction aligner in the IF stage; owns all C-extension fetch state the aligner consumes.
- Holds the instruction buffer, the "compressed at lo" flag, the spanning-instruction FSM and its two halfword captures, and the stall snapshot registers.
- Inputs come from the BRAM fetch word, the registered PC, the aligner's combinational outputs and the pipeline stall/flush controls.
- Outputs feed the aligner directly on the next cycle.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_instr  in  32  raw BRAM fetch word
- i_effective_instr  in  32  aligner's selected word (buffer or BRAM)
- i_pc_reg  in  32  registered PC; only bit 1 is used
- i_is_compressed  in  1  aligner parcel-type result
- i_holdoff  in  1  OR of non-spanning NOP sources (mid-32-bit correction, RAS holdoffs)
- i_stall  in  1  pipeline stall
- i_flush  in  1  control-flow redirect (trap, mret, mispredict, taken prediction)
- i_span_redirect  in  1  the spanning instruction being issued redirects fetch (predicted-taken)
- o_instr_buffer  out  32  buffered fetch word
- o_prev_was_compressed_at_lo  out  1
- o_spanning_wait_for_fetch  out  1
- o_spanning_in_progress  out  1
- o_spanning_buffer  out  16  first half of spanning instruction
- o_spanning_second_half  out  16
- o_spanning_to_halfword_registered  out  1
- o_use_buffer_after_spanning  out  1
- o_stall_registered  out  1
- o_prev_was_compressed_at_lo_saved  out  1
- o_is_compressed_saved  out  1
- o_saved_values_valid  out  1

Behaviour:
- Reset: all outputs and registers 0; FSM to IDLE. Reset takes effect immediately, including mid-span.
- adv = !i_stall && !i_flush. Priority: reset > flush > stall > normal.
- FSM states: IDLE, WAIT, READY, HW_HOLD, BUF_USE. Each state drives one output, registered/decoded without a combinational path from inputs:
  - WAIT drives spanning_wait_for_fetch.
  - READY drives spanning_in_progress.
  - HW_HOLD drives spanning_to_halfword_registered.
  - BUF_USE drives use_buffer_after_spanning.
- start = (IDLE or BUF_USE) && adv && pc[1] && !i_is_compressed && !i_holdoff.
- IDLE/BUF_USE:
  - On start: spanning_buffer <= i_effective_instr[31:16]; go to WAIT.
  - Otherwise, if BUF_USE && adv: go to IDLE.
- WAIT, on adv: spanning_second_half <= i_instr[15:0]; instr_buffer <= i_instr; go to READY.
- READY, on adv: go to IDLE if i_span_redirect, else HW_HOLD. The next PC is always halfword-aligned, so the BRAM word is stale.
- HW_HOLD, on adv: go to BUF_USE.
- Latency: spanning instruction visible (in_progress) 2 advancing cycles after the first-half cycle; BRAM-stale NOP 1 cycle; buffer use the following cycle.
- prev_was_compressed_at_lo:
  - On adv it takes (!pc[1] && i_is_compressed && !i_holdoff && state==IDLE).
  - When that term is 1, instr_buffer <= i_instr in the same cycle.
  - Otherwise it holds on stall and clears on flush.
- stall_registered <= i_stall every cycle, including during flush.
- Snapshot: on i_stall && !stall_registered && !i_flush:
  - prev_was_compressed_at_lo_saved <= prev_was_compressed_at_lo
  - is_compressed_saved <= i_is_compressed
  - saved_values_valid <= 1
  - Snapshot registers hold while stalled.
- saved_values_valid clears on i_flush (same cycle edge) and on the first unstalled cycle (stall_registered && !i_stall).
- Flush: FSM to IDLE; prev flag and saved_values_valid to 0. Span data registers keep stale values, which is harmless because no state selects them.
- Flush and stall together: flush wins and state clears.
- Stall in any FSM state holds the state and all captures.

Decomposition:
- Shared if_stage package holds:
  - c_ext_state_e enum (IDLE, WAIT, READY, HW_HOLD, BUF_USE)
  - constants PARCEL_W=16 and RVC_OPCODE_32B=2'b11
- One natural sub-module: c_ext_stall_snapshot, containing stall_registered, the saved flags and valid.

Test Plan:
- Reset asserted mid-READY with spanning_buffer=16'hABCD -> all outputs 0 at once, state IDLE after deassert.
- PC=0x102, effective word 0x1234_0517, next BRAM word 0xFFFF_0123, no stall:
  - spanning_buffer=0x1234, then second_half=0x0123 with in_progress=1.
  - Then one cycle of spanning_to_halfword_registered, then one cycle of use_buffer_after_spanning, then IDLE.
- PC=0x100 with compressed lo parcel 0x4501 in word 0x8082_4501 -> prev_was_compressed_at_lo=1, instr_buffer=0x8082_4501.
- Stall raised for 3 cycles with prev flag=1, is_compressed=1:
  - saved flags=1, valid=1 throughout.
  - stall_registered drops 1 cycle after release; valid clears on the first unstalled cycle.
- Flush coincident with a WAIT-state stall -> IDLE, prev flag=0, saved_values_valid=0 next cycle.
- In BUF_USE with a noncompressed hi parcel (instr_buffer[17:16]=2'b11) -> spanning_buffer=instr_buffer[31:16], go to WAIT.
- In READY with i_span_redirect=1 -> IDLE, no HW_HOLD.
